// File: rtl/fifo_rd_packer.sv
// Read-side consumer of an asynchronous FIFO: pops entries, packs PACK of them
// little-endian into one wide word, and offers the word on a valid/ready stream.
module fifo_rd_packer #(
    parameter int DATASIZE = 8,
    parameter int PACK     = 4,
    parameter int CNTW     = 16
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst_n,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [DATASIZE-1:0]      fifo_rd_data,
    input  logic                     flush,
    output logic [PACK*DATASIZE-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(PACK)-1:0]  acc_cnt,
    output logic [CNTW-1:0]          word_cnt
);
    localparam int AW = $clog2(PACK);

    logic                               inflight_p0;
    logic [PACK-1:0][DATASIZE-1:0]      lanes_p1;
    logic [PACK-1:0][DATASIZE-1:0]      word_p1;
    logic [AW:0]                        fill;
    logic                               pop;
    logic                               capture;
    logic                               complete;
    logic                               accept;

    // fill == PACK-1 means the next pop completes a word, so the output
    // register must be empty or draining before that pop is issued.
    assign fill       = {1'b0, acc_cnt} + {{AW{1'b0}}, inflight_p0};
    assign fifo_rd_en = rd_rst_n && !fifo_empty && !flush &&
                        (int'(fill) != PACK - 1 || !out_valid || out_ready);
    assign pop        = fifo_rd_en && !fifo_empty;
    assign capture    = inflight_p0 && !flush;
    assign complete   = capture && (int'(acc_cnt) == PACK - 1);
    assign accept     = out_valid && out_ready;

    always_comb begin
        word_p1         = lanes_p1;
        word_p1[PACK-1] = fifo_rd_data;
    end

    // stage p1: lane capture of the entry returned one cycle after its pop
    always_ff @(posedge rd_clk) begin
        if (capture) begin
            lanes_p1[acc_cnt] <= fifo_rd_data;
        end
    end

    // stage p0/p1 control: pop tracking, lane index, output word and counter
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            inflight_p0 <= 1'b0;
            acc_cnt     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            word_cnt    <= '0;
        end else begin
            inflight_p0 <= pop;
            if (flush || complete) begin
                acc_cnt <= '0;
            end else if (capture) begin
                acc_cnt <= acc_cnt + AW'(1);
            end
            if (complete) begin
                out_data  <= word_p1;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                word_cnt <= word_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model with registered read data, queue-based
// reference of the packing rules, directed table, corner sequences, random run.
module tb_fifo_rd_packer;
    localparam int DATASIZE = 8;
    localparam int PACK     = 4;
    localparam int CNTW     = 4;  // small so the random run wraps word_cnt many times
    localparam int AW       = $clog2(PACK);
    localparam int WW       = PACK * DATASIZE;

    logic                rd_clk     = 1'b0;
    logic                rd_rst_n   = 1'b1;
    logic                fifo_empty = 1'b1;
    logic                fifo_rd_en;
    logic [DATASIZE-1:0] fifo_rd_data = '0;
    logic                flush      = 1'b0;
    logic [WW-1:0]       out_data;
    logic                out_valid;
    logic                out_ready  = 1'b0;
    logic [AW-1:0]       acc_cnt;
    logic [CNTW-1:0]     word_cnt;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_packer #(.DATASIZE(DATASIZE), .PACK(PACK), .CNTW(CNTW)) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .acc_cnt(acc_cnt), .word_cnt(word_cnt)
    );

    int total = 0;
    int bad   = 0;

    logic [DATASIZE-1:0] fifo_q[$];
    logic [DATASIZE-1:0] sent_q[$];
    logic [DATASIZE-1:0] partial[$];
    logic                m_inflight;
    logic [DATASIZE-1:0] m_data;
    logic                m_full;
    logic [WW-1:0]       m_word;
    int                  m_cnt;
    int                  delivered;
    bit                  sb_en;

    typedef struct {
        bit            gate;
        bit            fl;
        bit            rdy;
        bit            en;
        bit            vld;
        int            acc;
        int            wc;
        logic [WW-1:0] data;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        partial.delete();
        m_inflight = 1'b0;
        m_full     = 1'b0;
        m_cnt      = 0;
    endtask

    // Apply this cycle's inputs and compare the DUT against the reference.
    task automatic drive(input bit gate, input bit fl, input bit rdy);
        int slots;
        bit exp_en;
        fifo_empty = (fifo_q.size() == 0) || gate;
        flush      = fl;
        out_ready  = rdy;
        #1;
        slots  = PACK - partial.size() - int'(m_inflight);
        exp_en = !fifo_empty && !fl && (slots != 1 || !m_full || rdy);
        chk("rd_en", fifo_rd_en, exp_en);
        chk("out_valid", out_valid, m_full);
        if (m_full) chk("out_data", out_data, m_word);
        chk("acc_cnt", acc_cnt, partial.size());
        chk("word_cnt", word_cnt, m_cnt % (1 << CNTW));
    endtask

    // Advance the reference across one clock edge, then present FIFO read data.
    task automatic advance();
        logic          popped;
        logic [DATASIZE-1:0] b;
        popped = fifo_rd_en && !fifo_empty;
        if (m_full && out_ready) begin
            m_full = 1'b0;
            m_cnt++;
            delivered++;
            if (sb_en) begin
                for (int k = 0; k < PACK; k++) begin
                    if (sent_q.size() == 0) begin
                        chk("order_extra", 1, 0);
                    end else begin
                        b = sent_q.pop_front();
                        chk("order", out_data[k*DATASIZE +: DATASIZE], b);
                    end
                end
            end
        end
        if (m_inflight && !flush) begin
            partial.push_back(m_data);
            if (partial.size() == PACK) begin
                chk("no_overwrite", m_full, 0);
                for (int k = 0; k < PACK; k++) m_word[k*DATASIZE +: DATASIZE] = partial[k];
                m_full = 1'b1;
                partial.delete();
            end
        end
        if (flush) partial.delete();
        m_inflight = popped;
        if (popped) m_data = fifo_q.pop_front();
        @(posedge rd_clk);
        #1;
        fifo_rd_data = popped ? m_data : DATASIZE'($urandom);
    endtask

    task automatic run_until(input int target, input bit rdy, input int budget);
        int n;
        n = 0;
        while (delivered < target && n < budget) begin
            drive(1'b0, 1'b0, rdy);
            advance();
            n++;
        end
        if (delivered < target) chk("timeout", 0, 1);
    endtask

    initial begin
        bit found;
        sb_en     = 1'b0;
        delivered = 0;
        model_reset();

        // reset state
        fifo_empty = 1'b0;
        #2 rd_rst_n = 1'b0;
        repeat (2) @(posedge rd_clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_acc_cnt", acc_cnt, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        rd_rst_n = 1'b1;

        // directed: 8 entries, out_ready=1, cycle-by-cycle expectations
        tbl[0]  = '{0, 0, 1, 1, 0, 0, 0, '0};
        tbl[1]  = '{0, 0, 1, 1, 0, 0, 0, '0};
        tbl[2]  = '{0, 0, 1, 1, 0, 1, 0, '0};
        tbl[3]  = '{0, 0, 1, 1, 0, 2, 0, '0};
        tbl[4]  = '{0, 0, 1, 1, 0, 3, 0, '0};
        tbl[5]  = '{0, 0, 1, 1, 1, 0, 0, 32'h04030201};
        tbl[6]  = '{0, 0, 1, 1, 0, 1, 1, '0};
        tbl[7]  = '{0, 0, 1, 1, 0, 2, 1, '0};
        tbl[8]  = '{0, 0, 1, 0, 0, 3, 1, '0};
        tbl[9]  = '{0, 0, 1, 0, 1, 0, 1, 32'h08070605};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 2, '0};
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DATASIZE'(i));
        for (int c = 0; c < 11; c++) begin
            drive(tbl[c].gate, tbl[c].fl, tbl[c].rdy);
            chk("t1_rd_en", fifo_rd_en, tbl[c].en);
            chk("t1_valid", out_valid, tbl[c].vld);
            chk("t1_acc", acc_cnt, tbl[c].acc);
            chk("t1_wcnt", word_cnt, tbl[c].wc);
            if (tbl[c].vld) chk("t1_data", out_data, tbl[c].data);
            advance();
        end

        // backpressure: one word held, pops stall with acc_cnt=3
        for (int i = 0; i < 12; i++) fifo_q.push_back(DATASIZE'(8'h21 + i));
        repeat (12) begin
            drive(1'b0, 1'b0, 1'b0);
            advance();
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("t2_acc", acc_cnt, 3);
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 32'h24232221);
        chk("t2_stall", fifo_rd_en, 0);
        advance();
        run_until(delivered + 3, 1'b1, 40);
        drive(1'b0, 1'b0, 1'b1);
        chk("t2_wcnt", word_cnt, 5);
        advance();

        // flush a partial word, then a clean word follows
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        fifo_q.push_back(8'hCC);
        repeat (5) begin
            drive(1'b0, 1'b0, 1'b1);
            advance();
        end
        drive(1'b0, 1'b0, 1'b1);
        chk("t3_acc_pre", acc_cnt, 3);
        drive(1'b0, 1'b1, 1'b1);
        advance();
        drive(1'b0, 1'b0, 1'b1);
        chk("t3_acc_post", acc_cnt, 0);
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        fifo_q.push_back(8'h44);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (out_valid) begin
                chk("t3_data", out_data, 32'h44332211);
                found = 1'b1;
            end
            advance();
        end
        if (!found) chk("t3_timeout", 0, 1);

        // flush while the in-flight byte arrives, with a word pending
        for (int i = 0; i < 5; i++) fifo_q.push_back(DATASIZE'(8'h51 + i));
        repeat (5) begin
            drive(1'b0, 1'b0, 1'b0);
            advance();
        end
        drive(1'b0, 1'b1, 1'b0);
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, 32'h54535251);
        advance();
        drive(1'b0, 1'b0, 1'b0);
        chk("t4_acc", acc_cnt, 0);
        advance();
        drive(1'b0, 1'b0, 1'b1);
        chk("t4_pending", out_valid, 1);
        advance();
        drive(1'b0, 1'b0, 1'b1);
        chk("t4_wcnt", word_cnt, 7);
        chk("t4_acc_after", acc_cnt, 0);
        advance();

        // asynchronous reset mid-word
        for (int i = 0; i < 6; i++) fifo_q.push_back(DATASIZE'(8'h61 + i));
        repeat (8) begin
            drive(1'b0, 1'b0, 1'b0);
            advance();
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("t5_acc", acc_cnt, 2);
        chk("t5_valid", out_valid, 1);
        fifo_empty = 1'b0;
        #2 rd_rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_data", out_data, 0);
        chk("t5_rst_acc", acc_cnt, 0);
        chk("t5_rst_wcnt", word_cnt, 0);
        chk("t5_rst_rd_en", fifo_rd_en, 0);
        model_reset();
        fifo_q.delete();
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;

        // random empty/ready toggling against the byte scoreboard
        sb_en     = 1'b1;
        delivered = 0;
        sent_q.delete();
        for (int i = 0; i < 10000; i++) begin
            logic [DATASIZE-1:0] b;
            b = DATASIZE'($urandom);
            fifo_q.push_back(b);
            sent_q.push_back(b);
        end
        for (int n = 0; n < 60000 && delivered < 2500; n++) begin
            drive($urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 9) < 7);
            advance();
        end
        chk("t6_words", delivered, 2500);
        chk("t6_leftover", sent_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
